// File: rtl/cntr8_seq.sv
// Command sequencer for the 8-bit up/down counter: LOAD/WALK/CLEAR requests become load/inc/dec strobes.
// Define CNTR8_SEQ_CHECK_EN to build the shadow-vs-counter checker that drives err.
module cntr8_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_target,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             o_load,
  output logic             o_inc,
  output logic             o_dec,
  output logic [WIDTH-1:0] o_d_in,
  output logic             done,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_DONE} state_t;

  state_t           r_state;
  logic             r_ready;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_shadow;

  logic             w_accept;
  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH-1:0] w_load_val;
  logic             w_up;
  logic             w_dn;

  assign req_ready  = r_ready & ~reset;
  assign w_accept   = req_valid & req_ready & (r_state == S_IDLE);
  assign w_load_val = (req_op == 2'b00) ? req_target : '0;
  // Strobes are registered one cycle ahead, so the accepting edge compares against the live target
  assign w_tgt      = (r_state == S_IDLE) ? req_target : r_target;
  assign w_up       = r_shadow < w_tgt;
  assign w_dn       = r_shadow > w_tgt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_target <= '0;
      r_shadow <= '0;
      o_load   <= 1'b0;
      o_inc    <= 1'b0;
      o_dec    <= 1'b0;
      o_d_in   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ready  <= 1'b0;
            busy     <= 1'b1;
            r_target <= req_target;
            if (req_op == 2'b01) begin
              r_state <= S_STEP;
              o_inc   <= w_up;
              o_dec   <= w_dn;
              if (w_up) r_shadow <= r_shadow + 1'b1;
              else if (w_dn) r_shadow <= r_shadow - 1'b1;
            end else begin
              r_state  <= S_LOAD;
              o_load   <= 1'b1;
              o_d_in   <= w_load_val;
              r_shadow <= w_load_val;
            end
          end
        end
        S_LOAD: begin
          o_load  <= 1'b0;
          o_d_in  <= '0;
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_STEP: begin
          o_inc <= w_up;
          o_dec <= w_dn;
          if (w_up) r_shadow <= r_shadow + 1'b1;
          else if (w_dn) r_shadow <= r_shadow - 1'b1;
          // Shadow reached target: spend one strobe-free STEP cycle, then finish
          else if (!(o_inc | o_dec)) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CNTR8_SEQ_CHECK_EN
  logic [WIDTH-1:0] r_shadow_d1;

  // Shadow moves with the strobe; the counter follows one edge later
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow_d1 <= '0;
      err         <= 1'b0;
    end else begin
      r_shadow_d1 <= r_shadow;
      if (cnt_value != r_shadow_d1) err <= 1'b1;
    end
  end
`else
  logic w_unused_cnt;
  assign w_unused_cnt = ^cnt_value;
  assign err          = 1'b0;
`endif

endmodule
